// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and the queued writeback entry type.
package wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: FIFO of pending multdiv results with squash-by-register and live-match lookups.
//   clk, rst           clock, synchronous active-high reset
//   push_i/entry_i     enqueue an entry at the tail (ignored when full)
//   pop_i              dequeue the head (ignored when empty)
//   squash_i/_reg_i    clear live on every entry (incl. one pushed now) with that register
//   match_*_reg_i/_o   any live entry targets the given register
//   head_o, count_o, empty_o, full_o  queue state
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wb_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic                  squash_i,
    input  logic [REG_ADDR_W-1:0] squash_reg_i,
    input  logic [REG_ADDR_W-1:0] match_a_reg_i,
    input  logic [REG_ADDR_W-1:0] match_b_reg_i,
    output wb_entry_t             head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  match_a_o,
    output logic                  match_b_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    wb_entry_t     mem_q [DEPTH];
    logic          push_ok, pop_ok, push_live;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (PW+1)'(DEPTH);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        push_ok   = push_i && !full_o;
        pop_ok    = pop_i && !empty_o;
        push_live = push_entry_i.live && !(squash_i && squash_reg_i == push_entry_i.rd);
        wr_d      = wr_q + PW'(push_ok);
        rd_d      = rd_q + PW'(pop_ok);
        count_d   = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end

    // Live is cleared on pop as well, so a set live bit always marks an occupied slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i].live <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++)
                if (squash_i && mem_q[i].rd == squash_reg_i) mem_q[i].live <= 1'b0;
            if (pop_ok) mem_q[rd_q].live <= 1'b0;
            if (push_ok) begin
                mem_q[wr_q]      <= push_entry_i;
                mem_q[wr_q].live <= push_live;
            end
        end
    end

    always_comb begin
        match_a_o = 1'b0;
        match_b_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_a_o = match_a_o | (mem_q[i].live && mem_q[i].rd == match_a_reg_i);
            match_b_o = match_b_o | (mem_q[i].live && mem_q[i].rd == match_b_reg_i);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the pipeline and queued multdiv results.
//   clock, ctrl_reset              clock, synchronous active-high reset
//   pipe_we/_reg/_data             pipeline writeback, no backpressure, always wins the port
//   md_valid/_reg/_data, md_ready  multdiv result handshake into the queue
//   ctrl_readRegA/B, stall_A/B     decode hazard check against live queued destinations
//   ctrl_writeEnable/Reg, data_writeReg  registered register-file write port
//   q_count                        queue occupancy
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    input  logic                   pipe_we,
    input  logic [REG_ADDR_W-1:0]  pipe_reg,
    input  logic [DATA_W-1:0]      pipe_data,
    input  logic                   md_valid,
    input  logic [REG_ADDR_W-1:0]  md_reg,
    input  logic [DATA_W-1:0]      md_data,
    output logic                   md_ready,
    input  logic [REG_ADDR_W-1:0]  ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0]  ctrl_readRegB,
    output logic                   stall_A,
    output logic                   stall_B,
    output logic                   ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0]      data_writeReg,
    output logic [$clog2(DEPTH):0] q_count
);
    wb_entry_t             head, push_entry;
    logic                  empty, full, match_a, match_b;
    logic                  pipe_eff, push, pop, head_wr;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     data_q, data_d;

    assign md_ready   = !ctrl_reset && !full;
    assign push_entry = '{live: 1'b1, rd: md_reg, data: md_data};

    // Results to r0 are accepted but never queued; a popped dead entry still uses up the port.
    always_comb begin
        pipe_eff = pipe_we && pipe_reg != '0;
        push     = md_valid && md_ready && md_reg != '0;
        pop      = !ctrl_reset && !pipe_eff && !empty;
        head_wr  = pop && head.live;
        we_d     = pipe_eff || head_wr;
        reg_d    = pipe_eff ? pipe_reg : head_wr ? head.rd : reg_q;
        data_d   = pipe_eff ? pipe_data : head_wr ? head.data : data_q;
    end

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clock),
        .rst          (ctrl_reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .squash_i     (pipe_eff),
        .squash_reg_i (pipe_reg),
        .match_a_reg_i(ctrl_readRegA),
        .match_b_reg_i(ctrl_readRegB),
        .head_o       (head),
        .count_o      (q_count),
        .empty_o      (empty),
        .full_o       (full),
        .match_a_o    (match_a),
        .match_b_o    (match_b)
    );

    assign stall_A = ctrl_readRegA != '0 && match_a;
    assign stall_B = ctrl_readRegB != '0 && match_b;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1, pipe_we = 1'b0, md_valid = 1'b0;
    logic [4:0]  pipe_reg = '0, md_reg = '0, ctrl_readRegA = '0, ctrl_readRegB = '0;
    logic [31:0] pipe_data = '0, md_data = '0;
    logic        md_ready, stall_A, stall_B, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [$clog2(DEPTH):0] q_count;

    always #5 clock = ~clock;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .stall_A(stall_A), .stall_B(stall_B),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .q_count(q_count)
    );

    typedef struct {logic [4:0] r; logic [31:0] d; bit live;} ment_t;
    typedef struct {logic we; logic [4:0] r; logic [31:0] d;} wr_t;
    typedef struct {logic rdy; logic sa; logic sb; int cnt;} cmb_t;

    ment_t       mq[$];
    wr_t         wq[$];
    cmb_t        cq[$];
    logic [4:0]  last_r = '0;
    logic [31:0] last_d = '0;
    bit          started = 1'b0;
    int          checks = 0, errors = 0;
    cmb_t        mc;
    wr_t         mw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the current cycle's combinational outputs and the write port
    // registered by the previous edge against what the model queued up.
    always @(negedge clock) begin
        if (cq.size() > 0) begin
            mc = cq.pop_front();
            chk("md_ready", 32'(md_ready), 32'(mc.rdy));
            chk("stall_A", 32'(stall_A), 32'(mc.sa));
            chk("stall_B", 32'(stall_B), 32'(mc.sb));
            chk("q_count", 32'(q_count), 32'(mc.cnt));
        end
        if (wq.size() > 0) begin
            mw = wq.pop_front();
            chk("writeEnable", 32'(ctrl_writeEnable), 32'(mw.we));
            chk("writeReg", 32'(ctrl_writeReg), 32'(mw.r));
            chk("writeData", data_writeReg, mw.d);
        end
    end

    // One cycle: drive inputs, predict combinational outputs, then apply the
    // behavioural rules at the edge and queue the write port the next cycle should show.
    task automatic step(input logic rst, input logic pwe, input logic [4:0] preg,
                        input logic [31:0] pdata, input logic mv, input logic [4:0] mreg,
                        input logic [31:0] mdata, input logic [4:0] ra, input logic [4:0] rb);
        cmb_t  c;
        wr_t   w;
        ment_t e;
        bit    eff, rdy, ha, hb;
        ctrl_reset = rst; pipe_we = pwe; pipe_reg = preg; pipe_data = pdata;
        md_valid = mv; md_reg = mreg; md_data = mdata;
        ctrl_readRegA = ra; ctrl_readRegB = rb;
        eff = pwe && preg != 0;
        rdy = !rst && mq.size() < DEPTH;
        ha = 0; hb = 0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].r == ra) ha = 1;
            if (mq[i].live && mq[i].r == rb) hb = 1;
        end
        c.rdy = rdy; c.sa = ra != 0 && ha; c.sb = rb != 0 && hb; c.cnt = mq.size();
        if (started) cq.push_back(c);
        @(posedge clock);
        if (rst) begin
            mq.delete();
            last_r = '0; last_d = '0;
            w = '{1'b0, 5'd0, 32'd0};
        end else begin
            w = '{1'b0, last_r, last_d};
            if (eff) begin
                w = '{1'b1, preg, pdata};
                foreach (mq[i]) if (mq[i].r == preg) mq[i].live = 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) w = '{1'b1, e.r, e.d};
            end
            if (w.we) begin last_r = w.r; last_d = w.d; end
            if (mv && rdy && mreg != 0) mq.push_back('{mreg, mdata, !(eff && preg == mreg)});
        end
        wq.push_back(w);
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] ra);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // single result through the queue, stall on r5 until it pops
        step(0, 0, 0, 0, 1, 5, 32'h1234, 5, 0);
        idle(3, 5);
        // pipe busy for 4 cycles fills the queue, then r7, r8 drain in order
        step(0, 1, 1, 32'h11, 1, 7, 32'h77, 7, 8);
        step(0, 1, 2, 32'h22, 1, 8, 32'h88, 7, 8);
        step(0, 1, 3, 32'h33, 1, 10, 32'hAA, 7, 8);
        step(0, 1, 4, 32'h44, 1, 10, 32'hAA, 7, 8);
        idle(4, 8);
        // WAW squash of a queued r9
        step(0, 0, 0, 0, 1, 9, 32'hAAAA, 9, 0);
        step(0, 1, 9, 32'h5555, 0, 0, 0, 9, 0);
        idle(3, 9);
        // squash of an entry pushed in the same cycle
        step(0, 1, 6, 32'h66, 1, 6, 32'h6666, 6, 0);
        idle(3, 6);
        // pipe_we with r0 is idle: queue drains, no r0 strobe
        step(0, 0, 0, 0, 1, 3, 32'h3333, 3, 0);
        step(0, 1, 0, 32'hDEAD, 0, 0, 0, 3, 0);
        idle(2, 3);
        // md to r0 is discarded
        step(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        idle(2, 0);
        // reset with two entries queued drops them
        step(0, 1, 1, 32'h1, 1, 11, 32'hB, 11, 12);
        step(0, 1, 2, 32'h2, 1, 12, 32'hC, 11, 12);
        step(1, 0, 0, 0, 1, 13, 32'hD, 11, 12);
        step(0, 0, 0, 0, 1, 14, 32'hE, 14, 0);
        idle(3, 14);
        // back-to-back push and pop across pointer wrap
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 5'(k % 3 + 1), 32'h100 + k, 5'(k % 3 + 1), 0);
        idle(3, 0);
        // random traffic with occasional reset
        for (int k = 0; k < 500; k++)
            step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(6, 0);
        repeat (2) @(negedge clock);
        #1;
        if (wq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d write and %0d comb expectations left, required 0", wq.size(), cq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of entries in the long-latency result queue (power of two, 2..8).
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port ctrl_reset  input  1  reset, synchronous and active-high.
REQ-004 Port pipe_we  input  1  pipeline writeback request this cycle; it has no backpressure.
REQ-005 Port pipe_reg  input  5  pipeline destination register.
REQ-006 Port pipe_data  input  32  pipeline writeback data.
REQ-007 Port md_valid  input  1  multdiv result valid.
REQ-008 Port md_reg  input  5  multdiv destination register.
REQ-009 Port md_data  input  32  multdiv result data.
REQ-010 Port md_ready  output  1  queue can accept a multdiv result.
REQ-011 Port ctrl_readRegA  input  5  decode-stage source A, used for the hazard check.
REQ-012 Port ctrl_readRegB  input  5  decode-stage source B, used for the hazard check.
REQ-013 Port stall_A  output  1  source A matches a live queued destination.
REQ-014 Port stall_B  output  1  source B matches a live queued destination.
REQ-015 Port ctrl_writeEnable  output  1  registered write strobe to the register file.
REQ-016 Port ctrl_writeReg  output  5  registered write address to the register file.
REQ-017 Port data_writeReg  output  32  registered write data to the register file.
REQ-018 Port q_count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-019 A pipe write is effective when pipe_we=1 and pipe_reg!=0; pipe_we=1 with pipe_reg=0 is treated as an idle pipe cycle.
REQ-020 Priority: an effective pipe write always owns the register-file port; the queue head drains only in cycles with no effective pipe write.
REQ-021 The three write outputs are registered: a write selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
REQ-022 When nothing is selected in a cycle, the next cycle has ctrl_writeEnable=0, and ctrl_writeReg and data_writeReg hold their previous values.
REQ-023 md_ready = (q_count < DEPTH) and not ctrl_reset; it is purely a function of registered state and has no combinational path from md_valid.
REQ-024 A multdiv result is accepted on md_valid and md_ready; when md_reg!=0 it is enqueued at the tail with its live bit set, and when md_reg=0 it is accepted and discarded.
REQ-025 Multdiv results always pass through the queue with no bypass, so minimum latency from acceptance to the write strobe is 2 cycles.
REQ-026 The queue is FIFO; simultaneous push and pop leaves q_count unchanged, and the pointers wrap modulo DEPTH.
REQ-027 Queue full: md_ready=0 and md_valid is ignored; a pop in the same cycle does not raise md_ready until the next cycle.
REQ-028 Queue empty: no pop occurs and stall_A=stall_B=0.
REQ-029 WAW squash: an effective pipe write to register X clears the live bit of every queued entry whose register is X, including an entry pushed in the same cycle.
REQ-030 A popped entry with its live bit clear produces no write strobe but still frees its slot, and the port is consumed for that cycle.
REQ-031 stall_A=1 iff ctrl_readRegA!=0 and some live entry has register ctrl_readRegA; stall_B is defined the same way for ctrl_readRegB.
REQ-032 stall_A and stall_B are combinational from queue state and do not include an entry being pushed in the current cycle.

Reset
REQ-033 While ctrl_reset=1 at a clock edge, the block clears the pointers, q_count and all live bits, and sets ctrl_writeEnable=0, ctrl_writeReg=0 and data_writeReg=0.
REQ-034 While ctrl_reset=1, md_ready=0 and no push or pop occurs.
REQ-035 A reset asserted mid-operation drops queued results without writing them back.
REQ-036 The block accepts a multdiv result in the first cycle after ctrl_reset deasserts.

Structure
REQ-037 A shared package holds REG_ADDR_W=5, DATA_W=32 and the queue entry type {live, reg[4:0], data[31:0]}.
REQ-038 Sub-module wb_queue implements the FIFO, including the squash-by-register port and the live-match outputs; wb_arbiter holds the priority selection and the output registers.

Verification
REQ-039 Reset, then md push {r5, 0x1234} with the pipe idle: strobe r5=0x1234 two cycles after acceptance, and stall_A=1 for ctrl_readRegA=5 only until the pop.
REQ-040 Pipe writes continuously for 4 cycles while md pushes r7, r8 with DEPTH=2: md_ready falls to 0, and r7 then r8 are written in the first two pipe-idle cycles, in order.
REQ-041 md pushes {r9, 0xAAAA}, then a pipe write {r9, 0x5555} before the drain: the final write to r9 is 0x5555, and the squashed pop produces no strobe.
REQ-042 pipe_we=1 with pipe_reg=0 while an entry is queued: the queue drains that cycle, and there is no strobe to r0.
REQ-043 md accepts {r0, 0xFFFF}: q_count stays 0 and no strobe is produced; ctrl_reset asserted with 2 entries queued: q_count=0, no strobe, md_ready=1 on the cycle after release.
REQ-044 Push and pop in the same cycle over 10 consecutive results: q_count is stable, pointers wrap, and all 10 data values are written in order.
